// File: rtl/digit_pkg.sv
// Shared definitions for the digit window scroller.
//   DIGIT_W_DEFAULT : default bits per display digit
//   digit_t         : one display digit
//   BLANK_CODE      : digit code the segment decoders render as blank
//   clog2_min1      : $clog2 clamped to at least one bit, for index/counter widths
package digit_pkg;

   localparam int unsigned DIGIT_W_DEFAULT = 4;

   typedef logic [DIGIT_W_DEFAULT-1:0] digit_t;

   localparam digit_t BLANK_CODE = 4'hF;

   function automatic int unsigned clog2_min1(input int unsigned n);
      return (n <= 1) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/digit_window_scroller_edge_pulse.sv
// Rising-edge detector for a button level.
//   clk    : clock
//   R      : synchronous active-high reset; history bit loads RST_VAL
//   d      : level input
//   rise_c : combinational pulse, high when d=1 and the previous sample was 0
// RST_VAL=1 means a level already high when reset releases is not an edge.
module edge_pulse #(
   parameter logic RST_VAL = 1'b1
) (
   input  logic clk,
   input  logic R,
   input  logic d,
   output logic rise_c
);

   logic q;

   // Previous-cycle sample of d
   always_ff @(posedge clk) begin
      if (R) q <= RST_VAL;
      else   q <= d;
   end

   assign rise_c = d & ~q;

endmodule

// File: rtl/digit_window_scroller.sv
// Scrolling window of WIN adjacent digits over a latched bank of N_DIGITS digits.
//   clk     : clock
//   R       : synchronous active-high reset
//   d_in    : packed digit bank, digit k at [k*DIGIT_W +: DIGIT_W]
//   load    : capture d_in and return the window to offset 0
//   w1, w2  : scroll-down / scroll-up button levels (one step per rising edge)
//   auto_en : auto-scroll enable (only when DIGIT_WIN_AUTOSCROLL_EN is defined)
//   s_out   : window, slot j = digit (sel+j)
//   sel     : window offset, 0..N_DIGITS-WIN
//   at_min  : sel at 0
//   at_max  : sel at N_DIGITS-WIN
// Optional feature macro: DIGIT_WIN_AUTOSCROLL_EN adds a periodic wrapping
// auto-scroll every AUTO_PERIOD cycles.
module digit_window_scroller
   import digit_pkg::*;
#(
   parameter  int unsigned N_DIGITS    = 8,
   parameter  int unsigned WIN         = 3,
   parameter  int unsigned DIGIT_W     = DIGIT_W_DEFAULT,
   parameter  int unsigned AUTO_PERIOD = 50000000,
   localparam int unsigned SEL_W       = clog2_min1(N_DIGITS - WIN + 1)
) (
   input  logic                        clk,
   input  logic                        R,
   input  logic [N_DIGITS*DIGIT_W-1:0] d_in,
   input  logic                        load,
   input  logic                        w1,
   input  logic                        w2,
`ifdef DIGIT_WIN_AUTOSCROLL_EN
   input  logic                        auto_en,
`endif
   output logic [WIN*DIGIT_W-1:0]      s_out,
   output logic [SEL_W-1:0]            sel,
   output logic                        at_min,
   output logic                        at_max
);

   localparam int unsigned MAX_SEL = N_DIGITS - WIN;
   localparam int unsigned IDX_W   = clog2_min1(N_DIGITS);
   localparam int unsigned VEC_W   = N_DIGITS * DIGIT_W;

   localparam logic [SEL_W-1:0] SEL_MAX = SEL_W'(MAX_SEL);
   localparam logic [SEL_W-1:0] SEL_ONE = SEL_W'(1);

   // Reject nonsensical configurations at elaboration
   if (WIN < 1 || WIN > N_DIGITS || AUTO_PERIOD < 1) begin : g_param_check
      $error("digit_window_scroller: need 1 <= WIN <= N_DIGITS and AUTO_PERIOD >= 1");
   end

   logic [VEC_W-1:0] digits_q, digits_d;
   logic [SEL_W-1:0] sel_q, sel_d;
   logic             up, dn;
   logic             auto_step;
   logic             sel_lo, sel_hi, sel_top;

   edge_pulse #(.RST_VAL(1'b1)) u_edge_dn (
      .clk    (clk),
      .R      (R),
      .d      (w1),
      .rise_c (dn)
   );

   edge_pulse #(.RST_VAL(1'b1)) u_edge_up (
      .clk    (clk),
      .R      (R),
      .d      (w2),
      .rise_c (up)
   );

   // sel_hi only covers unreachable codes above MAX_SEL; they are pulled back into range
   assign sel_lo  = (sel_q == '0);
   assign sel_hi  = (sel_q > SEL_MAX);
   assign sel_top = sel_hi || (sel_q == SEL_MAX);

`ifdef DIGIT_WIN_AUTOSCROLL_EN
   localparam int unsigned      TMR_W  = clog2_min1(AUTO_PERIOD);
   localparam logic [TMR_W-1:0] TMR_TC = TMR_W'(AUTO_PERIOD - 1);

   logic [TMR_W-1:0] timer_q, timer_d;

   // Auto-scroll timer; any load, button edge or disable restarts the period
   always_comb begin
      timer_d   = '0;
      auto_step = auto_en && (timer_q == TMR_TC);
      if (!(load || up || dn || !auto_en || auto_step)) begin
         timer_d = timer_q + TMR_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (R) timer_q <= '0;
      else   timer_q <= timer_d;
   end
`else
   assign auto_step = 1'b0;
`endif

   // Next digit bank and offset: load > both edges > single edge > auto step
   always_comb begin
      digits_d = digits_q;
      sel_d    = sel_q;
      if (load) begin
         digits_d = d_in;
         sel_d    = '0;
      end else if (up && dn) begin
         sel_d = sel_q;
      end else if (up) begin
         if (sel_hi)        sel_d = SEL_MAX;
         else if (!sel_top) sel_d = sel_q + SEL_ONE;
      end else if (dn) begin
         if (sel_hi)        sel_d = SEL_MAX;
         else if (!sel_lo)  sel_d = sel_q - SEL_ONE;
      end else if (auto_step) begin
         sel_d = sel_top ? '0 : sel_q + SEL_ONE;
      end
   end

   always_ff @(posedge clk) begin
      if (R) begin
         digits_q <= '0;
         sel_q    <= '0;
      end else begin
         digits_q <= digits_d;
         sel_q    <= sel_d;
      end
   end

   // Window mux: split the bank into digits, then pick digit sel+j for slot j
   logic [DIGIT_W-1:0] dig [N_DIGITS];

   for (genvar k = 0; k < N_DIGITS; k++) begin : g_split
      assign dig[k] = digits_q[k*DIGIT_W +: DIGIT_W];
   end

   for (genvar j = 0; j < WIN; j++) begin : g_win
      logic [IDX_W-1:0] idx;
      assign idx = IDX_W'(sel_q) + IDX_W'(j);
      assign s_out[j*DIGIT_W +: DIGIT_W] = dig[idx];
   end

   assign sel    = sel_q;
   assign at_min = sel_lo;
   assign at_max = (sel_q == SEL_MAX);

endmodule

// File: tb/tb_digit_window_scroller.sv
// Bench for digit_window_scroller (N_DIGITS=8, WIN=3, DIGIT_W=4, AUTO_PERIOD=4).
// Define DIGIT_WIN_AUTOSCROLL_EN to also exercise the auto-scroll feature.
module tb_digit_window_scroller;

   localparam int ND  = 8;
   localparam int W   = 3;
   localparam int DW  = 4;
   localparam int AP  = 4;
   localparam int MAX = ND - W;

   logic          clk = 1'b0;
   logic          R = 1'b1;
   logic [31:0]   d_in = '0;
   logic          load = 1'b0;
   logic          w1 = 1'b0;
   logic          w2 = 1'b0;
   logic          auto_en = 1'b0;
   logic [11:0]   s_out;
   logic [2:0]    sel;
   logic          at_min;
   logic          at_max;

   int total = 0;
   int bad   = 0;
   bit checking = 1'b0;

   // Reference state: digit bank, offset, previous button levels, timer
   logic [3:0] m_dig [ND];
   int         m_sel = 0;
   bit         m_pw1 = 1'b1;
   bit         m_pw2 = 1'b1;
   int         m_tmr = 0;

   digit_window_scroller #(
      .N_DIGITS    (ND),
      .WIN         (W),
      .DIGIT_W     (DW),
      .AUTO_PERIOD (AP)
   ) dut (
      .clk     (clk),
      .R       (R),
      .d_in    (d_in),
      .load    (load),
      .w1      (w1),
      .w2      (w2),
`ifdef DIGIT_WIN_AUTOSCROLL_EN
      .auto_en (auto_en),
`endif
      .s_out   (s_out),
      .sel     (sel),
      .at_min  (at_min),
      .at_max  (at_max)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   function automatic logic [11:0] exp_win();
      logic [11:0] r;
      for (int j = 0; j < W; j++) r[j*4 +: 4] = m_dig[m_sel + j];
      return r;
   endfunction

   // Reference model: apply the scrolling rules to the inputs seen at each edge
   always @(posedge clk) begin : model
      bit up, dn, a;
`ifdef DIGIT_WIN_AUTOSCROLL_EN
      a = auto_en;
`else
      a = 1'b0;
`endif
      if (R) begin
         for (int k = 0; k < ND; k++) m_dig[k] = '0;
         m_sel = 0;
         m_pw1 = 1'b1;
         m_pw2 = 1'b1;
         m_tmr = 0;
      end else begin
         up = w2 && !m_pw2;
         dn = w1 && !m_pw1;
         m_pw1 = w1;
         m_pw2 = w2;
         if (load) begin
            for (int k = 0; k < ND; k++) m_dig[k] = d_in[k*4 +: 4];
            m_sel = 0;
         end else if (up && dn) begin
            m_sel = m_sel;
         end else if (up) begin
            m_sel = (m_sel < MAX) ? m_sel + 1 : MAX;
         end else if (dn) begin
            m_sel = (m_sel > 0) ? m_sel - 1 : 0;
         end else if (a && m_tmr == AP - 1) begin
            m_sel = (m_sel + 1) % (MAX + 1);
         end
         m_tmr = (load || up || dn || !a) ? 0 : (m_tmr + 1) % AP;
      end
   end

   // Every-cycle comparison against the model
   always @(negedge clk) begin
      if (checking) begin
         chk("cyc_sel",    32'(sel),    32'(m_sel));
         chk("cyc_s_out",  32'(s_out),  32'(exp_win()));
         chk("cyc_at_min", 32'(at_min), 32'(m_sel == 0));
         chk("cyc_at_max", 32'(at_max), 32'(m_sel == MAX));
      end
   end

   task automatic tick(input int n = 1);
      repeat (n) @(negedge clk);
   endtask

   task automatic press_up(input int n);
      repeat (n) begin w2 = 1'b1; tick(); w2 = 1'b0; tick(); end
   endtask

   task automatic press_dn(input int n);
      repeat (n) begin w1 = 1'b1; tick(); w1 = 1'b0; tick(); end
   endtask

   initial begin
      tick();
      checking = 1'b1;
      chk("rst_sel",    32'(sel),    32'd0);
      chk("rst_s_out",  32'(s_out),  32'd0);
      chk("rst_at_min", 32'(at_min), 32'd1);
      chk("rst_at_max", 32'(at_max), 32'd0);

      R = 1'b0; load = 1'b1; d_in = 32'h87654321; tick(); load = 1'b0;
      chk("load_s_out", 32'(s_out), 32'h321);
      chk("load_sel",   32'(sel),   32'd0);

      w2 = 1'b1; tick(10);
      chk("held_sel",   32'(sel),   32'd1);
      chk("held_s_out", 32'(s_out), 32'h432);
      w2 = 1'b0; tick();

      press_up(6);
      chk("top_sel",    32'(sel),    32'd5);
      chk("top_s_out",  32'(s_out),  32'h876);
      chk("top_at_max", 32'(at_max), 32'd1);
      press_up(1);
      chk("sat_sel",    32'(sel),    32'd5);

      press_dn(3);
      chk("dn3_sel", 32'(sel), 32'd2);
      w1 = 1'b1; w2 = 1'b1; tick();
      chk("both_sel", 32'(sel), 32'd2);
      w1 = 1'b0; w2 = 1'b0; tick();
      press_dn(3);
      chk("floor_sel", 32'(sel), 32'd0);

      press_up(3);
      chk("pre_ld_sel", 32'(sel), 32'd3);
      w2 = 1'b1; load = 1'b1; d_in = 32'hFEDCBA98; tick(); load = 1'b0;
      chk("ld_edge_sel",   32'(sel),   32'd0);
      chk("ld_edge_s_out", 32'(s_out), 32'hA98);

      // w2 still held from the load cycle through a reset pulse
      R = 1'b1; tick(2); R = 1'b0; tick(3);
      chk("rst_held_sel",   32'(sel),   32'd0);
      chk("rst_held_s_out", 32'(s_out), 32'd0);
      w2 = 1'b0; tick(); w2 = 1'b1; tick();
      chk("repress_sel", 32'(sel), 32'd1);
      w2 = 1'b0; tick();

      load = 1'b1; d_in = 32'h87654321; tick(); load = 1'b0;
      press_up(4);
      chk("mid_s_out", 32'(s_out), 32'h765);
      R = 1'b1; tick(); R = 1'b0;
      chk("mid_rst_sel",   32'(sel),   32'd0);
      chk("mid_rst_s_out", 32'(s_out), 32'd0);

`ifdef DIGIT_WIN_AUTOSCROLL_EN
      load = 1'b1; d_in = 32'h87654321; tick(); load = 1'b0;
      press_up(5);
      auto_en = 1'b1; tick(3);
      chk("auto_wait_sel", 32'(sel), 32'd5);
      tick();
      chk("auto_wrap_sel", 32'(sel), 32'd0);
      tick(2);
      w1 = 1'b1; tick();
      tick(3);
      chk("auto_rst_tmr_sel", 32'(sel), 32'd0);
      tick();
      chk("auto_step_sel", 32'(sel), 32'd1);
      w1 = 1'b0; auto_en = 1'b0; tick();
`endif

      // Randomised phases biased upward then downward so both limits get hit
      for (int c = 0; c < 4000; c++) begin
         bit upward;
         upward = ((c / 500) % 2) == 0;
         R    = ($urandom_range(0, 199) == 0);
         load = ($urandom_range(0, 63) == 0);
         d_in = $urandom();
         if ($urandom_range(0, upward ? 1 : 7) == 0) w2 = ~w2;
         if ($urandom_range(0, upward ? 7 : 1) == 0) w1 = ~w1;
         if ($urandom_range(0, 39) == 0) auto_en = ~auto_en;
         tick();
      end

      checking = 1'b0;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
